teclado_matriz_fifo: RTL

//  Parametrised matrix-keypad scanner: N_ROWS x N_COLS, active-low rows/columns.

---
 rtl/teclado_matriz_fifo.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/teclado_matriz_fifo.sv
// Matrix-keypad scanner with frame-level debounce and a registered-head event FIFO.
// Define KEYPAD_REPEAT_EN to re-push a held key (REPEAT_DELAY / REPEAT_RATE frames).
module teclado_matriz_fifo #(
    parameter int N_ROWS          = 4,
    parameter int N_COLS          = 4,
    parameter int CICLOS_SCAN     = 1000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int FIFO_DEPTH      = 4,
`ifdef KEYPAD_REPEAT_EN
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_RATE     = 10,
`endif
    localparam int CODE_W = $clog2(N_ROWS*N_COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_COLS-1:0] column,
    output logic [N_ROWS-1:0] row,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              multi_key,
    output logic              overflow
);

    localparam int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int COL_W  = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int CNT_W  = $clog2(CICLOS_SCAN);
    localparam int DB_W   = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {ST_SCAN, ST_EVAL} state_t;

    logic [N_COLS-1:0] r_col_meta, r_col_sync;
    state_t            r_state;
    logic [ROW_W-1:0]  r_row_idx;
    logic [CNT_W-1:0]  r_cyc_cnt;
    logic [N_ROWS-1:0] r_row;
    logic [1:0]        r_hits;
    logic [CODE_W-1:0] r_hit_code;
    logic              r_cand_none, r_acc_none, r_multi;
    logic [CODE_W-1:0] r_cand_code, r_acc_code;
    logic [DB_W-1:0]   r_db_cnt;

    logic [1:0]        w_row_cnt, w_hits_sat;
    logic [2:0]        w_hits_sum;
    logic [COL_W-1:0]  w_row_col;
    logic [CODE_W-1:0] w_row_code;
    logic              w_last_cyc, w_last_row;
    logic              w_multi, w_cand_none, w_same, w_is_acc, w_accept, w_repeat, w_push;
    logic [DB_W-1:0]   w_db_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col_meta <= '1;
            r_col_sync <= '1;
        end else begin
            // NOTE: non-blocking assignments so both flops sample the pre-edge values.
            r_col_meta <= column;
            r_col_sync <= r_col_meta;
        end
    end

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        w_row_cnt = '0;
        w_row_col = '0;
        for (int c = 0; c < N_COLS; c++) begin
            if (!r_col_sync[c]) begin
                if (w_row_cnt == 2'd0) w_row_col = COL_W'(c);
                if (w_row_cnt != 2'd2) w_row_cnt = w_row_cnt + 2'd1;
            end
        end
    end

    assign w_row_code = CODE_W'(int'(r_row_idx) * N_COLS + int'(w_row_col));
    assign w_hits_sum = {1'b0, r_hits} + {1'b0, w_row_cnt};
    assign w_hits_sat = (w_hits_sum > 3'd1) ? 2'd2 : w_hits_sum[1:0];
    assign w_last_cyc = (r_cyc_cnt == CNT_W'(CICLOS_SCAN - 1));
    assign w_last_row = (r_row_idx == ROW_W'(N_ROWS - 1));

    // Frame verdict: multi-contact frames never match a candidate and restart the debounce.
    assign w_multi     = (r_hits == 2'd2);
    assign w_cand_none = (r_hits != 2'd1);
    assign w_same      = (w_cand_none == r_cand_none) && (w_cand_none || r_hit_code == r_cand_code);
    assign w_is_acc    = (w_cand_none == r_acc_none) && (w_cand_none || r_hit_code == r_acc_code);
    assign w_db_next   = w_multi ? '0 :
                         !w_same ? DB_W'(1) :
                         (r_db_cnt == DB_W'(DEBOUNCE_FRAMES)) ? r_db_cnt : r_db_cnt + DB_W'(1);
    assign w_accept    = (r_state == ST_EVAL) && !w_multi && !w_is_acc &&
                         (w_db_next == DB_W'(DEBOUNCE_FRAMES));
    assign w_push      = (w_accept && !w_cand_none) || w_repeat;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] r_rep_cnt, w_rep_next;
    logic             r_rep_first, w_held;

    assign w_held     = (r_state == ST_EVAL) && !w_cand_none && w_is_acc;
    assign w_rep_next = r_rep_cnt + REP_W'(1);
    assign w_repeat   = w_held &&
                        (w_rep_next == (r_rep_first ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_RATE)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (r_state == ST_EVAL) begin
            if (!w_held) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b1;
            end else if (w_repeat) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b0;
            end else begin
                r_rep_cnt   <= w_rep_next;
            end
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_SCAN;
            r_row_idx   <= '0;
            r_cyc_cnt   <= '0;
            r_row       <= '1;
            r_hits      <= '0;
            r_hit_code  <= '0;
            r_cand_none <= 1'b1;
            r_cand_code <= '0;
            r_db_cnt    <= '0;
            r_acc_none  <= 1'b1;
            r_acc_code  <= '0;
            r_multi     <= 1'b0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    r_row <= ~(N_ROWS'(1) << r_row_idx);
                    if (w_last_cyc) begin
                        r_cyc_cnt <= '0;
                        r_hits    <= w_hits_sat;
                        if (r_hits == 2'd0 && w_row_cnt == 2'd1) r_hit_code <= w_row_code;
                        if (w_last_row) begin
                            r_state   <= ST_EVAL;
                            r_row_idx <= '0;
                            r_row     <= '1;
                        end else begin
                            r_row_idx <= r_row_idx + ROW_W'(1);
                            r_row     <= ~(N_ROWS'(1) << (r_row_idx + ROW_W'(1)));
                        end
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
                    end
                end
                ST_EVAL: begin
                    r_state     <= ST_SCAN;
                    r_row       <= ~N_ROWS'(1);
                    r_hits      <= '0;
                    r_multi     <= w_multi;
                    r_db_cnt    <= w_db_next;
                    r_cand_none <= w_cand_none;
                    r_cand_code <= r_hit_code;
                    if (w_accept) begin
                        r_acc_none <= w_cand_none;
                        r_acc_code <= r_hit_code;
                    end
                end
                default: r_state <= ST_SCAN;
            endcase
        end
    end

    logic [CODE_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr, w_next_rd;
    logic [FCNT_W-1:0] r_count, w_cnt_after_pop, w_next_count;
    logic [CODE_W-1:0] r_key_code, w_head;
    logic              r_key_valid, r_overflow, w_pop, w_full, w_push_ok;

    // A pop frees the slot in the same cycle, so a push onto a full FIFO with a pop is kept.
    assign w_pop           = r_key_valid && key_ready;
    assign w_full          = (r_count == FCNT_W'(FIFO_DEPTH));
    assign w_push_ok       = w_push && (!w_full || w_pop);
    assign w_cnt_after_pop = r_count - FCNT_W'(w_pop);
    assign w_next_count    = w_cnt_after_pop + FCNT_W'(w_push_ok);
    assign w_next_rd       = r_rd_ptr + PTR_W'(w_pop);
    assign w_head          = (w_cnt_after_pop == '0) ? r_hit_code : r_mem[w_next_rd];

    // NOTE: storage is not reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= r_hit_code;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_rd_ptr    <= w_next_rd;
            r_count     <= w_next_count;
            r_key_valid <= (w_next_count != '0);
            if (w_next_count != '0) r_key_code <= w_head;
            if (w_push && !w_push_ok) r_overflow <= 1'b1;
        end
    end

    assign row       = r_row;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign multi_key = r_multi;
    assign overflow  = r_overflow;

endmodule
